race_start_sequencer: RTL and testbench
=======================================

Name: race_start_sequencer

Overview:
Sequences a single drag race once the menu raises start_game. It runs a timed amber-light countdown, then asserts green. It detects false starts and the first finisher, counts race duration, and holds the result until the menu drops start_game. It sits between the menu flag logic and the car physics, HUD and result drawing blocks.

Parameters:
TICKS_PER_STEP, 65_000_000, clk cycles per countdown step (1 s at 65 MHz); benches override with a small value.
NUM_LIGHTS, 3, number of amber countdown lights.
TIME_W, 32, width of race_ticks counter.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous, active-high reset.
start_game  input  1  level from menu; a rising edge starts a race, low aborts or releases.
throttle_p1  input  1  player 1 throttle key level.
throttle_p2  input  1  player 2 throttle key level.
finish_p1  input  1  player 1 car crossed finish line (level).
finish_p2  input  1  player 2 car crossed finish line (level).
lights  output  NUM_LIGHTS  amber lights, thermometer coded, bit 0 lit first.
green  output  1  go light.
race_active  output  1  cars may move.
false_start  output  2  bit0 = p1, bit1 = p2.
winner  output  2  0 none, 1 p1, 2 p2, 3 draw.
race_done  output  1  result valid.
race_ticks  output  TIME_W  clk cycles spent in RACE.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high. All outputs are registered.
- Reset: state = IDLE; all outputs 0; step counter, tick counter and start_game edge register cleared.
- Edge detect: start_d <= start_game every cycle. A start edge is start_game & ~start_d.
- IDLE:
  - On a start edge, go to COUNTDOWN next cycle.
  - Clear tick_cnt, step, lights, false_start, winner, race_ticks.
- COUNTDOWN:
  - tick_cnt counts 0..TICKS_PER_STEP-1.
  - At terminal count: tick_cnt -> 0 and step++. If step < NUM_LIGHTS, lights <= thermometer(step+1).
  - On the terminal count of step NUM_LIGHTS: go to RACE, lights <= 0, green <= 1, race_active <= 1.
  - Green therefore rises (NUM_LIGHTS+1)*TICKS_PER_STEP cycles after the first COUNTDOWN cycle.
- False start (COUNTDOWN only):
  - throttle_pX high in any COUNTDOWN cycle, including the first: go to DONE next cycle, set false_start[X-1].
  - winner = the other player; if both throttles are high in the same cycle, false_start = 2'b11 and winner = 3.
  - A false start takes priority over a terminal count in the same cycle.
- RACE:
  - race_ticks increments each cycle and saturates at all-ones.
  - First cycle with finish_p1 | finish_p2 high: go to DONE. winner = 1 if only p1, 2 if only p2, 3 if both the same cycle.
  - Throttle is ignored in RACE.
- DONE: race_done = 1, green = 0, race_active = 0, lights = 0. winner, false_start and race_ticks are frozen. Stays until start_game = 0, then IDLE.
- Abort: start_game = 0 in COUNTDOWN or RACE -> IDLE next cycle, all outputs cleared. A new race needs a fresh rising edge.
- A start_game held high after DONE does not restart a race; only a 0->1 edge seen in IDLE does.
- rst asserted mid-race behaves as full reset on the next edge.
- Finish inputs are ignored outside RACE.
- Size target: ~150-250 lines RTL.

Test Plan:
- Nominal start (TICKS_PER_STEP=4, NUM_LIGHTS=3): raise start_game at cycle 0.
  - Required: COUNTDOWN at cycle 1; lights = 001 at cycle 5, 011 at 9, 111 at 13.
  - Required: green = race_active = 1 and lights = 000 at cycle 17.
- Finish p2 first: after green, assert finish_p2 8 cycles later.
  - Required: winner = 2, race_done = 1, race_ticks = 8, green = 0.
  - Later finish_p1 does not change the result.
- Simultaneous finish: both finish inputs high in the same RACE cycle -> winner = 3.
- False start: throttle_p1 high during lights = 011.
  - Required: next cycle DONE, false_start = 01, winner = 2, race_ticks = 0.
  - Both throttles high in the same cycle -> false_start = 11, winner = 3.
- Abort and restart: drop start_game mid-COUNTDOWN -> IDLE next cycle, all outputs 0.
  - Holding start_game high after DONE does not restart.
  - Low then high restarts the countdown from lights = 000.
- Reset: assert rst during RACE -> all outputs 0 next cycle. race_ticks saturation is checked with TIME_W = 4 (stays at 15).

Source files
------------

// File: rtl/race_start_if.sv
// Signal bundle between the menu/controls side and the race start sequencer.
// The sequencer uses the slave view; the menu/bench drives through the master view.
interface race_start_if #(
  parameter int NUM_LIGHTS = 3,
  parameter int TIME_W     = 32
);
  logic                  start_game;
  logic                  throttle_p1;
  logic                  throttle_p2;
  logic                  finish_p1;
  logic                  finish_p2;
  logic [NUM_LIGHTS-1:0] lights;
  logic                  green;
  logic                  race_active;
  logic [1:0]            false_start;
  logic [1:0]            winner;
  logic                  race_done;
  logic [TIME_W-1:0]     race_ticks;

  modport slave (
    input  start_game, throttle_p1, throttle_p2, finish_p1, finish_p2,
    output lights, green, race_active, false_start, winner, race_done, race_ticks
  );

  modport master (
    output start_game, throttle_p1, throttle_p2, finish_p1, finish_p2,
    input  lights, green, race_active, false_start, winner, race_done, race_ticks
  );
endinterface

// File: rtl/race_start_sequencer.sv
// Drag race sequencer: amber countdown, green light, false-start and finish
// detection, race duration count; result held until the menu drops start_game.
module race_start_sequencer #(
  parameter int TICKS_PER_STEP = 65_000_000,
  parameter int NUM_LIGHTS     = 3,
  parameter int TIME_W         = 32
) (
  input  logic        clk,
  input  logic        rst,
  race_start_if.slave bus
);
  localparam int TICK_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam int STEP_W = $clog2(NUM_LIGHTS + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_STEP - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_LIGHTS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNTDOWN,
    S_RACE,
    S_DONE
  } state_t;

  state_t                r_state, w_state_next;
  logic                  r_start_d;
  logic [TICK_W-1:0]     r_tick, w_tick_next;
  logic [STEP_W-1:0]     r_step, w_step_next;
  logic [NUM_LIGHTS-1:0] r_lights, w_lights_next;
  logic                  r_green, w_green_next;
  logic                  r_race_active, w_race_active_next;
  logic [1:0]            r_false_start, w_false_start_next;
  logic [1:0]            r_winner, w_winner_next;
  logic                  r_race_done, w_race_done_next;
  logic [TIME_W-1:0]     r_race_ticks, w_race_ticks_next;

  logic                  w_start_edge;
  logic [NUM_LIGHTS-1:0] w_thermo;

  assign w_start_edge = bus.start_game & ~r_start_d;

  // Lights pattern for the step about to begin: bits 0..r_step lit.
  generate
    for (genvar gi = 0; gi < NUM_LIGHTS; gi++) begin : g_thermo
      assign w_thermo[gi] = (r_step >= STEP_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_start_d     <= 1'b0;
      r_tick        <= '0;
      r_step        <= '0;
      r_lights      <= '0;
      r_green       <= 1'b0;
      r_race_active <= 1'b0;
      r_false_start <= 2'b00;
      r_winner      <= 2'b00;
      r_race_done   <= 1'b0;
      r_race_ticks  <= '0;
    end else begin
      r_state       <= w_state_next;
      r_start_d     <= bus.start_game;
      r_tick        <= w_tick_next;
      r_step        <= w_step_next;
      r_lights      <= w_lights_next;
      r_green       <= w_green_next;
      r_race_active <= w_race_active_next;
      r_false_start <= w_false_start_next;
      r_winner      <= w_winner_next;
      r_race_done   <= w_race_done_next;
      r_race_ticks  <= w_race_ticks_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_tick_next        = r_tick;
    w_step_next        = r_step;
    w_lights_next      = r_lights;
    w_green_next       = r_green;
    w_race_active_next = r_race_active;
    w_false_start_next = r_false_start;
    w_winner_next      = r_winner;
    w_race_done_next   = r_race_done;
    w_race_ticks_next  = r_race_ticks;

    case (r_state)
      S_IDLE: begin
        if (w_start_edge) begin
          w_state_next = S_COUNTDOWN;
        end
      end

      S_COUNTDOWN: begin
        // Abort wins over a false start, which wins over the step timer.
        if (!bus.start_game) begin
          w_state_next = S_IDLE;
        end else if (bus.throttle_p1 | bus.throttle_p2) begin
          w_state_next       = S_DONE;
          w_false_start_next = {bus.throttle_p2, bus.throttle_p1};
          w_winner_next      = {bus.throttle_p1, bus.throttle_p2};
          w_race_done_next   = 1'b1;
          w_lights_next      = '0;
        end else if (r_tick == TICK_LAST) begin
          w_tick_next = '0;
          if (r_step == STEP_LAST) begin
            w_state_next       = S_RACE;
            w_step_next        = '0;
            w_lights_next      = '0;
            w_green_next       = 1'b1;
            w_race_active_next = 1'b1;
          end else begin
            w_step_next   = r_step + 1'b1;
            w_lights_next = w_thermo;
          end
        end else begin
          w_tick_next = r_tick + 1'b1;
        end
      end

      S_RACE: begin
        if (!bus.start_game) begin
          w_state_next = S_IDLE;
        end else if (bus.finish_p1 | bus.finish_p2) begin
          w_state_next       = S_DONE;
          w_winner_next      = {bus.finish_p2, bus.finish_p1};
          w_race_done_next   = 1'b1;
          w_green_next       = 1'b0;
          w_race_active_next = 1'b0;
        end else if (r_race_ticks != {TIME_W{1'b1}}) begin
          w_race_ticks_next = r_race_ticks + 1'b1;
        end
      end

      S_DONE: begin
        if (!bus.start_game) begin
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Entering or sitting in IDLE wipes every output and the countdown position.
    if (w_state_next == S_IDLE) begin
      w_tick_next        = '0;
      w_step_next        = '0;
      w_lights_next      = '0;
      w_green_next       = 1'b0;
      w_race_active_next = 1'b0;
      w_false_start_next = 2'b00;
      w_winner_next      = 2'b00;
      w_race_done_next   = 1'b0;
      w_race_ticks_next  = '0;
    end
  end

  assign bus.lights      = r_lights;
  assign bus.green       = r_green;
  assign bus.race_active = r_race_active;
  assign bus.false_start = r_false_start;
  assign bus.winner      = r_winner;
  assign bus.race_done   = r_race_done;
  assign bus.race_ticks  = r_race_ticks;
endmodule

// File: tb/tb_race_start_sequencer.sv
// Scoreboard bench for race_start_sequencer: expected output snapshots are queued
// with their cycle number as stimulus is applied, then popped and compared.
module tb_race_start_sequencer;
  localparam int TPS  = 4;
  localparam int NL   = 3;
  localparam int TW   = 32;
  localparam int TW_S = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  race_start_if #(.NUM_LIGHTS(NL), .TIME_W(TW))   bus   ();
  race_start_if #(.NUM_LIGHTS(NL), .TIME_W(TW_S)) bus_s ();

  race_start_sequencer #(.TICKS_PER_STEP(TPS), .NUM_LIGHTS(NL), .TIME_W(TW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  race_start_sequencer #(.TICKS_PER_STEP(TPS), .NUM_LIGHTS(NL), .TIME_W(TW_S)) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s)
  );

  typedef struct {
    int          cyc;
    logic [43:0] val;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [43:0] outs, outs_s;

  // Snapshot layout: lights, green, race_active, false_start, winner, race_done, race_ticks.
  assign outs   = {bus.lights, bus.green, bus.race_active, bus.false_start,
                   bus.winner, bus.race_done, bus.race_ticks};
  assign outs_s = {bus_s.lights, bus_s.green, bus_s.race_active, bus_s.false_start,
                   bus_s.winner, bus_s.race_done, 28'd0, bus_s.race_ticks};

  function automatic logic [43:0] ev(logic [2:0] l, logic g, logic a, logic [1:0] fs,
                                     logic [1:0] w, logic d, logic [31:0] t);
    return {l, g, a, fs, w, d, t};
  endfunction

  function automatic void expect_at(int c, string tag, logic [43:0] v);
    exp_t x;
    x.cyc = c;
    x.val = v;
    x.tag = tag;
    sb.push_back(x);
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    cyc = 0;
    expect_at(0, "reset_now", '0);
    expect_at(3, "reset_idle", '0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (outs !== e.val) begin failures++; $display("FAIL %s cyc=%0d actual=%h required=%h", e.tag, cyc, outs, e.val); end
      else $display("check %s cyc=%0d ok %h", e.tag, cyc, outs);
    end
    checks++;
    if (outs_s !== 44'd0) begin
      failures++;
      $display("FAIL reset_sat_dut actual=%h required=%h", outs_s, 44'd0);
    end else $display("check reset_sat_dut ok");
  endtask

  task automatic test_nominal_finish_p2();
    cyc = 0;
    bus.start_game = 1'b1;
    expect_at(1,  "cd_first",  '0);
    expect_at(4,  "cd_dark",   '0);
    expect_at(5,  "lights_1",  ev(3'b001, 0, 0, 0, 0, 0, 0));
    expect_at(8,  "lights_1b", ev(3'b001, 0, 0, 0, 0, 0, 0));
    expect_at(9,  "lights_2",  ev(3'b011, 0, 0, 0, 0, 0, 0));
    expect_at(13, "lights_3",  ev(3'b111, 0, 0, 0, 0, 0, 0));
    expect_at(16, "lights_3b", ev(3'b111, 0, 0, 0, 0, 0, 0));
    expect_at(17, "green_on",  ev(3'b000, 1, 1, 0, 0, 0, 0));
    expect_at(25, "race_t8",   ev(3'b000, 1, 1, 0, 0, 0, 8));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (outs !== e.val) begin failures++; $display("FAIL %s cyc=%0d actual=%h required=%h", e.tag, cyc, outs, e.val); end
      else $display("check %s cyc=%0d ok %h", e.tag, cyc, outs);
    end
    bus.finish_p2 = 1'b1;
    expect_at(26, "p2_wins", ev(3'b000, 0, 0, 2'b00, 2'd2, 1, 8));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (outs !== e.val) begin failures++; $display("FAIL %s cyc=%0d actual=%h required=%h", e.tag, cyc, outs, e.val); end
      else $display("check %s cyc=%0d ok %h", e.tag, cyc, outs);
    end
    bus.finish_p1 = 1'b1;
    expect_at(30, "p1_late_ignored", ev(3'b000, 0, 0, 2'b00, 2'd2, 1, 8));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (outs !== e.val) begin failures++; $display("FAIL %s cyc=%0d actual=%h required=%h", e.tag, cyc, outs, e.val); end
      else $display("check %s cyc=%0d ok %h", e.tag, cyc, outs);
    end
    bus.start_game = 1'b0;
    bus.finish_p1  = 1'b0;
    bus.finish_p2  = 1'b0;
    expect_at(31, "release", '0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (outs !== e.val) begin failures++; $display("FAIL %s cyc=%0d actual=%h required=%h", e.tag, cyc, outs, e.val); end
      else $display("check %s cyc=%0d ok %h", e.tag, cyc, outs);
    end
  endtask

  task automatic test_simultaneous_finish();
    cyc = 0;
    bus.start_game = 1'b1;
    expect_at(17, "sim_green", ev(3'b000, 1, 1, 0, 0, 0, 0));
    expect_at(20, "sim_t3",    ev(3'b000, 1, 1, 0, 0, 0, 3));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (outs !== e.val) begin failures++; $display("FAIL %s cyc=%0d actual=%h required=%h", e.tag, cyc, outs, e.val); end
      else $display("check %s cyc=%0d ok %h", e.tag, cyc, outs);
    end
    bus.finish_p1 = 1'b1;
    bus.finish_p2 = 1'b1;
    expect_at(21, "sim_draw", ev(3'b000, 0, 0, 2'b00, 2'd3, 1, 3));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (outs !== e.val) begin failures++; $display("FAIL %s cyc=%0d actual=%h required=%h", e.tag, cyc, outs, e.val); end
      else $display("check %s cyc=%0d ok %h", e.tag, cyc, outs);
    end
    bus.start_game = 1'b0;
    bus.finish_p1  = 1'b0;
    bus.finish_p2  = 1'b0;
    expect_at(22, "sim_release", '0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (outs !== e.val) begin failures++; $display("FAIL %s cyc=%0d actual=%h required=%h", e.tag, cyc, outs, e.val); end
      else $display("check %s cyc=%0d ok %h", e.tag, cyc, outs);
    end
  endtask

  task automatic test_false_start();
    cyc = 0;
    bus.start_game = 1'b1;
    expect_at(9,  "fs_l2",  ev(3'b011, 0, 0, 0, 0, 0, 0));
    expect_at(10, "fs_l2b", ev(3'b011, 0, 0, 0, 0, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (outs !== e.val) begin failures++; $display("FAIL %s cyc=%0d actual=%h required=%h", e.tag, cyc, outs, e.val); end
      else $display("check %s cyc=%0d ok %h", e.tag, cyc, outs);
    end
    bus.throttle_p1 = 1'b1;
    expect_at(11, "fs_p1", ev(3'b000, 0, 0, 2'b01, 2'd2, 1, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (outs !== e.val) begin failures++; $display("FAIL %s cyc=%0d actual=%h required=%h", e.tag, cyc, outs, e.val); end
      else $display("check %s cyc=%0d ok %h", e.tag, cyc, outs);
    end
    bus.throttle_p1 = 1'b0;
    expect_at(21, "hold_no_restart", ev(3'b000, 0, 0, 2'b01, 2'd2, 1, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (outs !== e.val) begin failures++; $display("FAIL %s cyc=%0d actual=%h required=%h", e.tag, cyc, outs, e.val); end
      else $display("check %s cyc=%0d ok %h", e.tag, cyc, outs);
    end
    bus.start_game = 1'b0;
    expect_at(22, "done_release", '0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (outs !== e.val) begin failures++; $display("FAIL %s cyc=%0d actual=%h required=%h", e.tag, cyc, outs, e.val); end
      else $display("check %s cyc=%0d ok %h", e.tag, cyc, outs);
    end
    bus.start_game = 1'b1;
    expect_at(23, "restart_dark", '0);
    expect_at(27, "restart_l1",   ev(3'b001, 0, 0, 0, 0, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (outs !== e.val) begin failures++; $display("FAIL %s cyc=%0d actual=%h required=%h", e.tag, cyc, outs, e.val); end
      else $display("check %s cyc=%0d ok %h", e.tag, cyc, outs);
    end
    bus.throttle_p1 = 1'b1;
    bus.throttle_p2 = 1'b1;
    expect_at(28, "fs_both", ev(3'b000, 0, 0, 2'b11, 2'd3, 1, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (outs !== e.val) begin failures++; $display("FAIL %s cyc=%0d actual=%h required=%h", e.tag, cyc, outs, e.val); end
      else $display("check %s cyc=%0d ok %h", e.tag, cyc, outs);
    end
    bus.throttle_p1 = 1'b0;
    bus.throttle_p2 = 1'b0;
    bus.start_game  = 1'b0;
    expect_at(29, "fs_release", '0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (outs !== e.val) begin failures++; $display("FAIL %s cyc=%0d actual=%h required=%h", e.tag, cyc, outs, e.val); end
      else $display("check %s cyc=%0d ok %h", e.tag, cyc, outs);
    end
  endtask

  task automatic test_abort_restart();
    cyc = 0;
    bus.start_game = 1'b1;
    bus.finish_p1  = 1'b1;
    expect_at(5, "ab_l1",  ev(3'b001, 0, 0, 0, 0, 0, 0));
    expect_at(7, "ab_l1b", ev(3'b001, 0, 0, 0, 0, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (outs !== e.val) begin failures++; $display("FAIL %s cyc=%0d actual=%h required=%h", e.tag, cyc, outs, e.val); end
      else $display("check %s cyc=%0d ok %h", e.tag, cyc, outs);
    end
    bus.start_game = 1'b0;
    bus.finish_p1  = 1'b0;
    expect_at(8,  "abort_idle", '0);
    expect_at(10, "abort_stay", '0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (outs !== e.val) begin failures++; $display("FAIL %s cyc=%0d actual=%h required=%h", e.tag, cyc, outs, e.val); end
      else $display("check %s cyc=%0d ok %h", e.tag, cyc, outs);
    end
    bus.start_game = 1'b1;
    expect_at(11, "re_dark",  '0);
    expect_at(14, "re_dark2", '0);
    expect_at(15, "re_l1",    ev(3'b001, 0, 0, 0, 0, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (outs !== e.val) begin failures++; $display("FAIL %s cyc=%0d actual=%h required=%h", e.tag, cyc, outs, e.val); end
      else $display("check %s cyc=%0d ok %h", e.tag, cyc, outs);
    end
    bus.start_game = 1'b0;
    expect_at(16, "re_release", '0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (outs !== e.val) begin failures++; $display("FAIL %s cyc=%0d actual=%h required=%h", e.tag, cyc, outs, e.val); end
      else $display("check %s cyc=%0d ok %h", e.tag, cyc, outs);
    end
  endtask

  task automatic test_reset_mid_race();
    cyc = 0;
    bus.start_game = 1'b1;
    expect_at(17, "rr_green", ev(3'b000, 1, 1, 0, 0, 0, 0));
    expect_at(20, "rr_t3",    ev(3'b000, 1, 1, 0, 0, 0, 3));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (outs !== e.val) begin failures++; $display("FAIL %s cyc=%0d actual=%h required=%h", e.tag, cyc, outs, e.val); end
      else $display("check %s cyc=%0d ok %h", e.tag, cyc, outs);
    end
    rst = 1'b1;
    expect_at(21, "rr_cleared", '0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (outs !== e.val) begin failures++; $display("FAIL %s cyc=%0d actual=%h required=%h", e.tag, cyc, outs, e.val); end
      else $display("check %s cyc=%0d ok %h", e.tag, cyc, outs);
    end
    rst            = 1'b0;
    bus.start_game = 1'b0;
    expect_at(23, "rr_idle", '0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (outs !== e.val) begin failures++; $display("FAIL %s cyc=%0d actual=%h required=%h", e.tag, cyc, outs, e.val); end
      else $display("check %s cyc=%0d ok %h", e.tag, cyc, outs);
    end
  endtask

  task automatic test_saturation();
    cyc = 0;
    bus_s.start_game = 1'b1;
    expect_at(17, "sat_green", ev(3'b000, 1, 1, 0, 0, 0, 0));
    expect_at(24, "sat_t7",    ev(3'b000, 1, 1, 0, 0, 0, 7));
    expect_at(31, "sat_t14",   ev(3'b000, 1, 1, 0, 0, 0, 14));
    expect_at(32, "sat_t15",   ev(3'b000, 1, 1, 0, 0, 0, 15));
    expect_at(40, "sat_hold",  ev(3'b000, 1, 1, 0, 0, 0, 15));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (outs_s !== e.val) begin failures++; $display("FAIL %s cyc=%0d actual=%h required=%h", e.tag, cyc, outs_s, e.val); end
      else $display("check %s cyc=%0d ok %h", e.tag, cyc, outs_s);
    end
    bus_s.finish_p1 = 1'b1;
    expect_at(41, "sat_p1_wins", ev(3'b000, 0, 0, 2'b00, 2'd1, 1, 15));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (outs_s !== e.val) begin failures++; $display("FAIL %s cyc=%0d actual=%h required=%h", e.tag, cyc, outs_s, e.val); end
      else $display("check %s cyc=%0d ok %h", e.tag, cyc, outs_s);
    end
    bus_s.finish_p1  = 1'b0;
    bus_s.start_game = 1'b0;
    expect_at(42, "sat_release", '0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.cyc) tick();
      checks++;
      if (outs_s !== e.val) begin failures++; $display("FAIL %s cyc=%0d actual=%h required=%h", e.tag, cyc, outs_s, e.val); end
      else $display("check %s cyc=%0d ok %h", e.tag, cyc, outs_s);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_game    = 1'b0;
    bus.throttle_p1   = 1'b0;
    bus.throttle_p2   = 1'b0;
    bus.finish_p1     = 1'b0;
    bus.finish_p2     = 1'b0;
    bus_s.start_game  = 1'b0;
    bus_s.throttle_p1 = 1'b0;
    bus_s.throttle_p2 = 1'b0;
    bus_s.finish_p1   = 1'b0;
    bus_s.finish_p2   = 1'b0;
    test_reset();
    test_nominal_finish_p2();
    test_simultaneous_finish();
    test_false_start();
    test_abort_restart();
    test_reset_mid_race();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
